// File: rtl/reservation_station.sv
// reservation_station
// Arithmetic/branch reservation station for the Tomasulo core. It buffers
// issued non-memory instructions and captures missing operands from the ALU
// and LSB common data buses by ROB tag. Each cycle it sends at most one ready
// entry (the lowest index) to the ALU through registered alu_* outputs.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global ready, low stalls the station
//   rob_clear           misprediction flush, empties every entry
//   rs_full             high when at most one free entry remains
//   issue_*             allocation channel from the issue unit
//   alu_cdb_*, lsb_cdb_* result broadcasts used for operand wakeup
//   alu_*               registered dispatch to the ALU, alu_enable pulses
module reservation_station #(
   parameter int RS_SIZE = 16,
   parameter int RS_LOG  = 4,
   parameter int ROB_LOG = 4,
   parameter int OP_LOG  = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic               rob_clear,
   output logic               rs_full,
   input  logic               issue_enable,
   input  logic [OP_LOG-1:0]  issue_op,
   input  logic [31:0]        issue_Vj,
   input  logic [31:0]        issue_Vk,
   input  logic               issue_Rj,
   input  logic               issue_Rk,
   input  logic [ROB_LOG-1:0] issue_Qj,
   input  logic [ROB_LOG-1:0] issue_Qk,
   input  logic [31:0]        issue_Imm,
   input  logic [31:0]        issue_CurPc,
   input  logic [ROB_LOG-1:0] issue_RobId,
   input  logic               alu_cdb_valid,
   input  logic [ROB_LOG-1:0] alu_cdb_RobId,
   input  logic [31:0]        alu_cdb_value,
   input  logic               lsb_cdb_valid,
   input  logic [ROB_LOG-1:0] lsb_cdb_RobId,
   input  logic [31:0]        lsb_cdb_value,
   output logic               alu_enable,
   output logic [OP_LOG-1:0]  alu_op,
   output logic [31:0]        alu_Vj,
   output logic [31:0]        alu_Vk,
   output logic [31:0]        alu_Imm,
   output logic [31:0]        alu_CurPc,
   output logic [ROB_LOG-1:0] alu_RobId
);

   // Entry storage
   logic [RS_SIZE-1:0] busy_r;
   logic [RS_SIZE-1:0] rj_r;
   logic [RS_SIZE-1:0] rk_r;
   logic [OP_LOG-1:0]  op_r    [RS_SIZE];
   logic [31:0]        vj_r    [RS_SIZE];
   logic [31:0]        vk_r    [RS_SIZE];
   logic [ROB_LOG-1:0] qj_r    [RS_SIZE];
   logic [ROB_LOG-1:0] qk_r    [RS_SIZE];
   logic [31:0]        imm_r   [RS_SIZE];
   logic [31:0]        pc_r    [RS_SIZE];
   logic [ROB_LOG-1:0] robid_r [RS_SIZE];

   logic              free_found_s;
   logic [RS_LOG-1:0] free_idx_s;
   logic [RS_LOG:0]   free_cnt_s;
   logic              ready_found_s;
   logic [RS_LOG-1:0] ready_idx_s;
   logic [31:0]       issue_vj_s;
   logic [31:0]       issue_vk_s;
   logic              issue_rj_s;
   logic              issue_rk_s;

   // Lowest free slot, free-slot count and lowest ready slot, all from registered state.
   // Scanning downwards lets the lowest matching index overwrite the others.
   always_comb begin
      free_found_s  = 1'b0;
      free_idx_s    = '0;
      free_cnt_s    = '0;
      ready_found_s = 1'b0;
      ready_idx_s   = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!busy_r[i]) begin
            free_found_s = 1'b1;
            free_idx_s   = RS_LOG'(i);
            free_cnt_s   = free_cnt_s + (RS_LOG+1)'(1);
         end else begin
            free_cnt_s   = free_cnt_s;
         end
         if (busy_r[i] && rj_r[i] && rk_r[i]) begin
            ready_found_s = 1'b1;
            ready_idx_s   = RS_LOG'(i);
         end else begin
            ready_found_s = ready_found_s;
         end
      end
   end

   assign rs_full = (free_cnt_s <= (RS_LOG+1)'(1));

   // Issue-side bypass: an operand broadcast in the same cycle it is issued is captured directly.
   always_comb begin
      issue_vj_s = issue_Vj;
      issue_rj_s = issue_Rj;
      issue_vk_s = issue_Vk;
      issue_rk_s = issue_Rk;
      if (!issue_Rj && alu_cdb_valid && (alu_cdb_RobId == issue_Qj)) begin
         issue_vj_s = alu_cdb_value;
         issue_rj_s = 1'b1;
      end else if (!issue_Rj && lsb_cdb_valid && (lsb_cdb_RobId == issue_Qj)) begin
         issue_vj_s = lsb_cdb_value;
         issue_rj_s = 1'b1;
      end else begin
         issue_rj_s = issue_Rj;
      end
      if (!issue_Rk && alu_cdb_valid && (alu_cdb_RobId == issue_Qk)) begin
         issue_vk_s = alu_cdb_value;
         issue_rk_s = 1'b1;
      end else if (!issue_Rk && lsb_cdb_valid && (lsb_cdb_RobId == issue_Qk)) begin
         issue_vk_s = lsb_cdb_value;
         issue_rk_s = 1'b1;
      end else begin
         issue_rk_s = issue_Rk;
      end
   end

   // Entry state and dispatch register: reset > flush > stall > wakeup/dispatch/issue.
   // The issue slot comes from registered busy bits, so an entry freed by this
   // cycle's dispatch is never the one written by this cycle's issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r     <= '0;
         alu_enable <= 1'b0;
         alu_op     <= '0;
         alu_Vj     <= 32'h0;
         alu_Vk     <= 32'h0;
         alu_Imm    <= 32'h0;
         alu_CurPc  <= 32'h0;
         alu_RobId  <= '0;
      end else if (rob_clear) begin
         busy_r     <= '0;
         alu_enable <= 1'b0;
      end else if (!rdy) begin
         alu_enable <= 1'b0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_r[i] && !rj_r[i] && alu_cdb_valid && (alu_cdb_RobId == qj_r[i])) begin
               vj_r[i] <= alu_cdb_value;
               rj_r[i] <= 1'b1;
            end else if (busy_r[i] && !rj_r[i] && lsb_cdb_valid && (lsb_cdb_RobId == qj_r[i])) begin
               vj_r[i] <= lsb_cdb_value;
               rj_r[i] <= 1'b1;
            end
            if (busy_r[i] && !rk_r[i] && alu_cdb_valid && (alu_cdb_RobId == qk_r[i])) begin
               vk_r[i] <= alu_cdb_value;
               rk_r[i] <= 1'b1;
            end else if (busy_r[i] && !rk_r[i] && lsb_cdb_valid && (lsb_cdb_RobId == qk_r[i])) begin
               vk_r[i] <= lsb_cdb_value;
               rk_r[i] <= 1'b1;
            end
         end
         if (ready_found_s) begin
            alu_enable          <= 1'b1;
            alu_op              <= op_r[ready_idx_s];
            alu_Vj              <= vj_r[ready_idx_s];
            alu_Vk              <= vk_r[ready_idx_s];
            alu_Imm             <= imm_r[ready_idx_s];
            alu_CurPc           <= pc_r[ready_idx_s];
            alu_RobId           <= robid_r[ready_idx_s];
            busy_r[ready_idx_s] <= 1'b0;
         end else begin
            alu_enable <= 1'b0;
         end
         if (issue_enable && free_found_s) begin
            busy_r[free_idx_s]  <= 1'b1;
            op_r[free_idx_s]    <= issue_op;
            vj_r[free_idx_s]    <= issue_vj_s;
            rj_r[free_idx_s]    <= issue_rj_s;
            qj_r[free_idx_s]    <= issue_Qj;
            vk_r[free_idx_s]    <= issue_vk_s;
            rk_r[free_idx_s]    <= issue_rk_s;
            qk_r[free_idx_s]    <= issue_Qk;
            imm_r[free_idx_s]   <= issue_Imm;
            pc_r[free_idx_s]    <= issue_CurPc;
            robid_r[free_idx_s] <= issue_RobId;
         end
      end
   end

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station.
module tb_reservation_station;

   localparam int ROB_LOG = 4;
   localparam int OP_LOG  = 5;

   logic               clk;
   logic               rst;
   logic               rdy;
   logic               rob_clear;
   logic               rs_full;
   logic               issue_enable;
   logic [OP_LOG-1:0]  issue_op;
   logic [31:0]        issue_Vj;
   logic [31:0]        issue_Vk;
   logic               issue_Rj;
   logic               issue_Rk;
   logic [ROB_LOG-1:0] issue_Qj;
   logic [ROB_LOG-1:0] issue_Qk;
   logic [31:0]        issue_Imm;
   logic [31:0]        issue_CurPc;
   logic [ROB_LOG-1:0] issue_RobId;
   logic               alu_cdb_valid;
   logic [ROB_LOG-1:0] alu_cdb_RobId;
   logic [31:0]        alu_cdb_value;
   logic               lsb_cdb_valid;
   logic [ROB_LOG-1:0] lsb_cdb_RobId;
   logic [31:0]        lsb_cdb_value;
   logic               alu_enable;
   logic [OP_LOG-1:0]  alu_op;
   logic [31:0]        alu_Vj;
   logic [31:0]        alu_Vk;
   logic [31:0]        alu_Imm;
   logic [31:0]        alu_CurPc;
   logic [ROB_LOG-1:0] alu_RobId;

   int checks = 0;
   int fails  = 0;

   reservation_station #(
      .RS_SIZE(16), .RS_LOG(4), .ROB_LOG(ROB_LOG), .OP_LOG(OP_LOG)
   ) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear), .rs_full(rs_full),
      .issue_enable(issue_enable), .issue_op(issue_op),
      .issue_Vj(issue_Vj), .issue_Vk(issue_Vk), .issue_Rj(issue_Rj), .issue_Rk(issue_Rk),
      .issue_Qj(issue_Qj), .issue_Qk(issue_Qk), .issue_Imm(issue_Imm),
      .issue_CurPc(issue_CurPc), .issue_RobId(issue_RobId),
      .alu_cdb_valid(alu_cdb_valid), .alu_cdb_RobId(alu_cdb_RobId), .alu_cdb_value(alu_cdb_value),
      .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_RobId(lsb_cdb_RobId), .lsb_cdb_value(lsb_cdb_value),
      .alu_enable(alu_enable), .alu_op(alu_op), .alu_Vj(alu_Vj), .alu_Vk(alu_Vk),
      .alu_Imm(alu_Imm), .alu_CurPc(alu_CurPc), .alu_RobId(alu_RobId)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_issue(input logic [OP_LOG-1:0] op, input logic [31:0] vj,
                              input logic [31:0] vk, input logic rj, input logic rk,
                              input logic [ROB_LOG-1:0] qj, input logic [ROB_LOG-1:0] qk,
                              input logic [31:0] imm, input logic [31:0] pc,
                              input logic [ROB_LOG-1:0] robid);
      issue_enable = 1'b1;
      issue_op     = op;
      issue_Vj     = vj;
      issue_Vk     = vk;
      issue_Rj     = rj;
      issue_Rk     = rk;
      issue_Qj     = qj;
      issue_Qk     = qk;
      issue_Imm    = imm;
      issue_CurPc  = pc;
      issue_RobId  = robid;
   endtask

   task automatic idle_inputs();
      issue_enable  = 1'b0;
      alu_cdb_valid = 1'b0;
      lsb_cdb_valid = 1'b0;
      alu_cdb_RobId = '0;
      lsb_cdb_RobId = '0;
      alu_cdb_value = 32'h0;
      lsb_cdb_value = 32'h0;
      rob_clear     = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL reset_en: got %0h want 0", alu_enable); end
      checks++; if (rs_full !== 1'b0) begin fails++; $display("FAIL reset_full: got %0h want 0", rs_full); end
      checks++; if (alu_op !== 5'h0) begin fails++; $display("FAIL reset_op: got %0h want 0", alu_op); end
      checks++; if ({alu_Vj, alu_Vk, alu_Imm, alu_CurPc} !== 128'h0) begin fails++; $display("FAIL reset_data: got %0h %0h %0h %0h want 0", alu_Vj, alu_Vk, alu_Imm, alu_CurPc); end
      checks++; if (alu_RobId !== 4'h0) begin fails++; $display("FAIL reset_robid: got %0h want 0", alu_RobId); end
   endtask

   task automatic test_ready_issue();
      drive_issue(5'd1, 32'd5, 32'd7, 1'b1, 1'b1, 4'd0, 4'd0, 32'h10, 32'h400, 4'd3);
      tick();
      idle_inputs();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL ready_t1_en: got %0h want 0", alu_enable); end
      tick();
      checks++; if (alu_enable !== 1'b1) begin fails++; $display("FAIL ready_t2_en: got %0h want 1", alu_enable); end
      checks++; if (alu_Vj !== 32'd5) begin fails++; $display("FAIL ready_vj: got %0h want 5", alu_Vj); end
      checks++; if (alu_Vk !== 32'd7) begin fails++; $display("FAIL ready_vk: got %0h want 7", alu_Vk); end
      checks++; if (alu_RobId !== 4'd3) begin fails++; $display("FAIL ready_robid: got %0h want 3", alu_RobId); end
      checks++; if (alu_op !== 5'd1) begin fails++; $display("FAIL ready_op: got %0h want 1", alu_op); end
      checks++; if (alu_CurPc !== 32'h400) begin fails++; $display("FAIL ready_pc: got %0h want 400", alu_CurPc); end
      tick();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL ready_t3_en: got %0h want 0", alu_enable); end
   endtask

   task automatic test_wakeup();
      drive_issue(5'd2, 32'h0, 32'd9, 1'b0, 1'b1, 4'd2, 4'd0, 32'h0, 32'h0, 4'd4);
      tick();
      idle_inputs();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL wake_t1_en: got %0h want 0", alu_enable); end
      alu_cdb_valid = 1'b1; alu_cdb_RobId = 4'd5; alu_cdb_value = 32'hDEAD;
      tick();
      idle_inputs();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL wake_t2_en: got %0h want 0", alu_enable); end
      tick();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL wake_t3_en: got %0h want 0", alu_enable); end
      alu_cdb_valid = 1'b1; alu_cdb_RobId = 4'd2; alu_cdb_value = 32'h1234;
      tick();
      idle_inputs();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL wake_t4_en: got %0h want 0", alu_enable); end
      tick();
      checks++; if (alu_enable !== 1'b1) begin fails++; $display("FAIL wake_t5_en: got %0h want 1", alu_enable); end
      checks++; if (alu_Vj !== 32'h1234) begin fails++; $display("FAIL wake_vj: got %0h want 1234", alu_Vj); end
      checks++; if (alu_Vk !== 32'd9) begin fails++; $display("FAIL wake_vk: got %0h want 9", alu_Vk); end
      checks++; if (alu_RobId !== 4'd4) begin fails++; $display("FAIL wake_robid: got %0h want 4", alu_RobId); end
      tick();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL wake_t6_en: got %0h want 0", alu_enable); end
   endtask

   task automatic test_bypass_lsb();
      drive_issue(5'd3, 32'd1, 32'h0, 1'b1, 1'b0, 4'd0, 4'd6, 32'h0, 32'h0, 4'd7);
      lsb_cdb_valid = 1'b1; lsb_cdb_RobId = 4'd6; lsb_cdb_value = 32'hBEEF;
      tick();
      idle_inputs();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL byp_t1_en: got %0h want 0", alu_enable); end
      tick();
      checks++; if (alu_enable !== 1'b1) begin fails++; $display("FAIL byp_t2_en: got %0h want 1", alu_enable); end
      checks++; if (alu_Vk !== 32'hBEEF) begin fails++; $display("FAIL byp_vk: got %0h want beef", alu_Vk); end
      checks++; if (alu_RobId !== 4'd7) begin fails++; $display("FAIL byp_robid: got %0h want 7", alu_RobId); end
      tick();
   endtask

   task automatic test_fill_order();
      logic exp_full;
      for (int i = 0; i < 16; i++) begin
         exp_full = (i >= 15);
         checks++; if (rs_full !== exp_full) begin fails++; $display("FAIL fill_full_%0d: got %0h want %0h", i, rs_full, exp_full); end
         drive_issue(5'd1, 32'h0, 32'(i), 1'b0, 1'b1, 4'(i), 4'd0, 32'(i), 32'h0, 4'(i));
         tick();
      end
      idle_inputs();
      checks++; if (rs_full !== 1'b1) begin fails++; $display("FAIL fill_full_16: got %0h want 1", rs_full); end
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL fill_no_disp: got %0h want 0", alu_enable); end
      // A ready issue while full must be dropped
      drive_issue(5'd2, 32'hDEAD, 32'h0, 1'b1, 1'b1, 4'd0, 4'd0, 32'h0, 32'h0, 4'd0);
      tick();
      idle_inputs();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL drop_t1_en: got %0h want 0", alu_enable); end
      tick();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL drop_t2_en: got %0h want 0", alu_enable); end
      // Tag 9 then tag 1 on consecutive cycles
      alu_cdb_valid = 1'b1; alu_cdb_RobId = 4'd9; alu_cdb_value = 32'h99;
      tick();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL ord_a1_en: got %0h want 0", alu_enable); end
      alu_cdb_RobId = 4'd1; alu_cdb_value = 32'h11;
      tick();
      idle_inputs();
      checks++; if (alu_enable !== 1'b1) begin fails++; $display("FAIL ord_a2_en: got %0h want 1", alu_enable); end
      checks++; if (alu_RobId !== 4'd9) begin fails++; $display("FAIL ord_a2_robid: got %0h want 9", alu_RobId); end
      checks++; if (alu_Vj !== 32'h99) begin fails++; $display("FAIL ord_a2_vj: got %0h want 99", alu_Vj); end
      checks++; if (alu_Imm !== 32'd9) begin fails++; $display("FAIL ord_a2_imm: got %0h want 9", alu_Imm); end
      checks++; if (rs_full !== 1'b1) begin fails++; $display("FAIL ord_a2_full: got %0h want 1", rs_full); end
      tick();
      checks++; if (alu_enable !== 1'b1) begin fails++; $display("FAIL ord_a3_en: got %0h want 1", alu_enable); end
      checks++; if (alu_RobId !== 4'd1) begin fails++; $display("FAIL ord_a3_robid: got %0h want 1", alu_RobId); end
      checks++; if (alu_Vj !== 32'h11) begin fails++; $display("FAIL ord_a3_vj: got %0h want 11", alu_Vj); end
      checks++; if (rs_full !== 1'b0) begin fails++; $display("FAIL ord_a3_full: got %0h want 0", rs_full); end
      tick();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL ord_a4_en: got %0h want 0", alu_enable); end
      // Simultaneous wakeup on both buses: lower index goes first
      alu_cdb_valid = 1'b1; alu_cdb_RobId = 4'd12; alu_cdb_value = 32'hC;
      lsb_cdb_valid = 1'b1; lsb_cdb_RobId = 4'd5;  lsb_cdb_value = 32'h5;
      tick();
      idle_inputs();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL sim_b1_en: got %0h want 0", alu_enable); end
      tick();
      checks++; if (alu_enable !== 1'b1) begin fails++; $display("FAIL sim_b2_en: got %0h want 1", alu_enable); end
      checks++; if (alu_RobId !== 4'd5) begin fails++; $display("FAIL sim_b2_robid: got %0h want 5", alu_RobId); end
      checks++; if (alu_Vj !== 32'h5) begin fails++; $display("FAIL sim_b2_vj: got %0h want 5", alu_Vj); end
      tick();
      checks++; if (alu_enable !== 1'b1) begin fails++; $display("FAIL sim_b3_en: got %0h want 1", alu_enable); end
      checks++; if (alu_RobId !== 4'd12) begin fails++; $display("FAIL sim_b3_robid: got %0h want c", alu_RobId); end
      checks++; if (alu_Vj !== 32'hC) begin fails++; $display("FAIL sim_b3_vj: got %0h want c", alu_Vj); end
      tick();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL sim_b4_en: got %0h want 0", alu_enable); end
   endtask

   task automatic test_flush();
      rob_clear = 1'b1;
      tick();
      rob_clear = 1'b0;
      checks++; if (rs_full !== 1'b0) begin fails++; $display("FAIL flush0_full: got %0h want 0", rs_full); end
      for (int i = 1; i <= 3; i++) begin
         drive_issue(5'd1, 32'h0, 32'h0, 1'b0, 1'b1, 4'(i), 4'd0, 32'h0, 32'h0, 4'(i));
         tick();
      end
      drive_issue(5'd6, 32'h8, 32'h8, 1'b1, 1'b1, 4'd0, 4'd0, 32'h0, 32'h0, 4'd8);
      tick();
      // Ready entry is selected this cycle; flush plus a same-cycle issue
      drive_issue(5'd6, 32'hA, 32'hA, 1'b1, 1'b1, 4'd0, 4'd0, 32'h0, 32'h0, 4'd10);
      rob_clear = 1'b1;
      tick();
      idle_inputs();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL flush_t1_en: got %0h want 0", alu_enable); end
      checks++; if (rs_full !== 1'b0) begin fails++; $display("FAIL flush_t1_full: got %0h want 0", rs_full); end
      alu_cdb_valid = 1'b1; alu_cdb_RobId = 4'd1; alu_cdb_value = 32'h7;
      tick();
      idle_inputs();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL flush_t2_en: got %0h want 0", alu_enable); end
      tick();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL flush_t3_en: got %0h want 0", alu_enable); end
      tick();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL flush_t4_en: got %0h want 0", alu_enable); end
      drive_issue(5'd4, 32'h11, 32'h22, 1'b1, 1'b1, 4'd0, 4'd0, 32'h33, 32'h1000, 4'd11);
      tick();
      idle_inputs();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL post_t1_en: got %0h want 0", alu_enable); end
      tick();
      checks++; if (alu_enable !== 1'b1) begin fails++; $display("FAIL post_t2_en: got %0h want 1", alu_enable); end
      checks++; if (alu_RobId !== 4'd11) begin fails++; $display("FAIL post_robid: got %0h want b", alu_RobId); end
      checks++; if (alu_op !== 5'd4) begin fails++; $display("FAIL post_op: got %0h want 4", alu_op); end
      checks++; if (alu_Imm !== 32'h33) begin fails++; $display("FAIL post_imm: got %0h want 33", alu_Imm); end
      checks++; if (alu_CurPc !== 32'h1000) begin fails++; $display("FAIL post_pc: got %0h want 1000", alu_CurPc); end
      tick();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL post_t3_en: got %0h want 0", alu_enable); end
   endtask

   task automatic test_stall();
      drive_issue(5'd7, 32'h13, 32'h13, 1'b1, 1'b1, 4'd0, 4'd0, 32'h0, 32'h0, 4'd13);
      tick();
      idle_inputs();
      rdy = 1'b0;
      tick();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL stall_t2_en: got %0h want 0", alu_enable); end
      drive_issue(5'd7, 32'h14, 32'h14, 1'b1, 1'b1, 4'd0, 4'd0, 32'h0, 32'h0, 4'd14);
      tick();
      idle_inputs();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL stall_t3_en: got %0h want 0", alu_enable); end
      rdy = 1'b1;
      tick();
      checks++; if (alu_enable !== 1'b1) begin fails++; $display("FAIL stall_t4_en: got %0h want 1", alu_enable); end
      checks++; if (alu_RobId !== 4'd13) begin fails++; $display("FAIL stall_robid: got %0h want d", alu_RobId); end
      tick();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL stall_t5_en: got %0h want 0", alu_enable); end
      tick();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL stall_t6_en: got %0h want 0", alu_enable); end
   endtask

   task automatic test_reset_mid();
      drive_issue(5'd3, 32'h15, 32'h15, 1'b1, 1'b1, 4'd0, 4'd0, 32'h0, 32'h0, 4'd15);
      tick();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL rstmid_en: got %0h want 0", alu_enable); end
      checks++; if (alu_RobId !== 4'd0) begin fails++; $display("FAIL rstmid_robid: got %0h want 0", alu_RobId); end
      checks++; if (alu_op !== 5'd0) begin fails++; $display("FAIL rstmid_op: got %0h want 0", alu_op); end
      checks++; if (alu_Vj !== 32'h0) begin fails++; $display("FAIL rstmid_vj: got %0h want 0", alu_Vj); end
      tick();
      checks++; if (alu_enable !== 1'b0) begin fails++; $display("FAIL rstmid_t2_en: got %0h want 0", alu_enable); end
      checks++; if (rs_full !== 1'b0) begin fails++; $display("FAIL rstmid_full: got %0h want 0", rs_full); end
   endtask

   initial begin
      rst = 1'b0;
      rdy = 1'b1;
      issue_op = '0; issue_Vj = 32'h0; issue_Vk = 32'h0; issue_Rj = 1'b0; issue_Rk = 1'b0;
      issue_Qj = '0; issue_Qk = '0; issue_Imm = 32'h0; issue_CurPc = 32'h0; issue_RobId = '0;
      idle_inputs();
      test_reset();
      test_ready_issue();
      test_wakeup();
      test_bypass_lsb();
      test_fill_order();
      test_flush();
      test_stall();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
